// File: rtl/fp_align.sv
// Operand alignment stage of the FP adder: unpack, order by magnitude, right-shift the smaller mantissa with guard/round/sticky.
// Optional build macro FP_ALIGN_SHORTCUT_EN: exponent differences of 26 or more finish without iterating SHIFT.
module fp_align #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        outValid,
  input  logic        outReady,
  output logic [23:0] mantissaLarge,
  output logic [23:0] mantissaSmall,
  output logic [7:0]  exponentOut,
  output logic        signLarge,
  output logic        signSmall,
  output logic        guardBit,
  output logic        roundBit,
  output logic        stickyBit,
  output logic        special
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [4:0] MAX_SHIFT = 5'd26;
  localparam logic [4:0] STEP_L    = 5'(STEP);

  logic [1:0]  state;
  logic [23:0] mant_l_p0;
  logic [26:0] small_p0;
  logic [7:0]  exp_p0;
  logic        sign_l_p0;
  logic        sign_s_p0;
  logic        special_p0;
  logic [4:0]  remain_p0;

  logic [7:0]  exp_a, exp_b, eff_a, eff_b;
  logic [23:0] mant_a, mant_b;
  logic        a_large;
  logic [7:0]  eff_l, eff_s, diff;
  logic [23:0] m_l, m_s;
  logic        s_l, s_s;
  logic        is_special;
  logic [4:0]  step_amt, remain_next;

  // Right shift of {mant, G, R, S}; everything passing through the S slot is ORed into it.
  function automatic logic [26:0] shift_sticky(input logic [26:0] v, input logic [4:0] k);
    logic [26:0] r;
    logic        s;
    r = v >> k;
    s = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (5'(i) <= k) s = s | v[i];
    end
    r[0] = s;
    return r;
  endfunction

  function automatic logic [4:0] clamp_shift(input logic [7:0] d);
    return (d >= 8'(MAX_SHIFT)) ? MAX_SHIFT : d[4:0];
  endfunction

  assign exp_a  = opA[30:23];
  assign exp_b  = opB[30:23];
  assign eff_a  = (exp_a == 8'd0) ? 8'd1 : exp_a;
  assign eff_b  = (exp_b == 8'd0) ? 8'd1 : exp_b;
  assign mant_a = {exp_a != 8'd0, opA[22:0]};
  assign mant_b = {exp_b != 8'd0, opB[22:0]};

  // Ties keep opA as the larger operand.
  assign a_large    = {eff_a, mant_a} >= {eff_b, mant_b};
  assign eff_l      = a_large ? eff_a : eff_b;
  assign eff_s      = a_large ? eff_b : eff_a;
  assign m_l        = a_large ? mant_a : mant_b;
  assign m_s        = a_large ? mant_b : mant_a;
  assign s_l        = a_large ? opA[31] : opB[31];
  assign s_s        = a_large ? opB[31] : opA[31];
  assign diff       = eff_l - eff_s;
  assign is_special = (exp_a == 8'hFF) || (exp_b == 8'hFF);

  assign step_amt    = (remain_p0 < STEP_L) ? remain_p0 : STEP_L;
  assign remain_next = remain_p0 - step_amt;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      mant_l_p0  <= '0;
      small_p0   <= '0;
      exp_p0     <= '0;
      sign_l_p0  <= 1'b0;
      sign_s_p0  <= 1'b0;
      special_p0 <= 1'b0;
      remain_p0  <= '0;
    end else begin
      case (state)
        // accept boundary: register ordered operands
        IDLE: begin
          if (inValid) begin
            mant_l_p0  <= m_l;
            sign_l_p0  <= s_l;
            sign_s_p0  <= s_s;
            special_p0 <= is_special;
            remain_p0  <= 5'd0;
            if (is_special) begin
              small_p0 <= {m_s, 3'b000};
              exp_p0   <= 8'hFF;
              state    <= DONE;
            end else if (diff == 8'd0) begin
              small_p0 <= {m_s, 3'b000};
              exp_p0   <= eff_l;
              state    <= DONE;
`ifdef FP_ALIGN_SHORTCUT_EN
            end else if (diff >= 8'(MAX_SHIFT)) begin
              small_p0 <= {26'd0, |m_s};
              exp_p0   <= eff_l;
              state    <= DONE;
`endif
            end else begin
              small_p0  <= {m_s, 3'b000};
              exp_p0    <= eff_l;
              remain_p0 <= clamp_shift(diff);
              state     <= SHIFT;
            end
          end
        end
        // shift boundary: up to STEP bits per cycle
        SHIFT: begin
          small_p0  <= shift_sticky(small_p0, step_amt);
          remain_p0 <= remain_next;
          if (remain_next == 5'd0) state <= DONE;
        end
        DONE: begin
          if (outReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign inReady       = (state == IDLE);
  assign outValid      = (state == DONE);
  assign mantissaLarge = mant_l_p0;
  assign mantissaSmall = small_p0[26:3];
  assign guardBit      = small_p0[2];
  assign roundBit      = small_p0[1];
  assign stickyBit     = small_p0[0];
  assign exponentOut   = exp_p0;
  assign signLarge     = sign_l_p0;
  assign signSmall     = sign_s_p0;
  assign special       = special_p0;

endmodule

// File: tb/tb_fp_align.sv
// Bench for fp_align: directed vector table, backpressure/reset sequences, and random operands against an arithmetic model.
module tb_fp_align;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] opA, opB;
  logic        outValid;
  logic        outReady;
  logic [23:0] mantissaLarge, mantissaSmall;
  logic [7:0]  exponentOut;
  logic        signLarge, signSmall, guardBit, roundBit, stickyBit, special;

  fp_align #(.STEP(STEP)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .opA(opA), .opB(opB), .outValid(outValid), .outReady(outReady),
    .mantissaLarge(mantissaLarge), .mantissaSmall(mantissaSmall),
    .exponentOut(exponentOut), .signLarge(signLarge), .signSmall(signSmall),
    .guardBit(guardBit), .roundBit(roundBit), .stickyBit(stickyBit),
    .special(special)
  );

  always #5 clk = ~clk;

`ifdef FP_ALIGN_SHORTCUT_EN
  localparam bit SHORTCUT = 1'b1;
`else
  localparam bit SHORTCUT = 1'b0;
`endif
  localparam int FAR_LAT = SHORTCUT ? 1 : 1 + (26 + STEP - 1) / STEP;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a, b;
    logic [23:0] ml, ms;
    logic [7:0]  e;
    logic        sl, ss, g, r, s, sp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[8];

  logic [61:0] cap;
  int          cap_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [61:0] outs();
    return {mantissaLarge, mantissaSmall, exponentOut, signLarge, signSmall,
            guardBit, roundBit, stickyBit, special};
  endfunction

  // Reference: exact shift of the smaller significand by d in 64-bit arithmetic, then fold lost bits into sticky.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [61:0] res, output int lat);
    int          ea, eb, effa, effb, effl, effs, diff, d, dlat;
    longint      ma, mb, ml, ms, full, keep, lost;
    logic        sl, ss, sp, g, r, s;
    logic [23:0] ms_out;
    logic [7:0]  e;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    effa = (ea == 0) ? 1 : ea;
    effb = (eb == 0) ? 1 : eb;
    ma   = longint'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
    mb   = longint'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
    if (longint'(effa) * 16777216 + ma >= longint'(effb) * 16777216 + mb) begin
      effl = effa; effs = effb; ml = ma; ms = mb; sl = a[31]; ss = b[31];
    end else begin
      effl = effb; effs = effa; ml = mb; ms = ma; sl = b[31]; ss = a[31];
    end
    sp   = (ea == 255) || (eb == 255);
    diff = effl - effs;
    d    = (diff > 26) ? 26 : diff;
    if (sp) begin
      ms_out = 24'(ms); e = 8'hFF; g = 0; r = 0; s = 0; dlat = 0;
    end else begin
      full   = ms * 8;
      keep   = full >> d;
      lost   = full & ((64'd1 << d) - 1);
      ms_out = 24'(keep >> 3);
      g      = keep[2];
      r      = keep[1];
      s      = keep[0] | (lost != 0);
      e      = 8'(effl);
      dlat   = (SHORTCUT && diff >= 26) ? 0 : d;
    end
    lat = 1 + (dlat + STEP - 1) / STEP;
    res = {24'(ml), ms_out, e, sl, ss, g, r, s, sp};
  endtask

  // Presents one pair, waits for outValid, holds backpressure for 'hold' cycles, then hands off.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int cyc;
    opA = a; opB = b; inValid = 1'b1;
    chk("in_ready_idle", 64'(inReady), 64'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
    cyc = 0;
    while (!outValid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("out_valid_reached", 64'(outValid), 64'd1);
    cap_lat = cyc + 1;
    cap     = outs();
    chk("in_ready_busy", 64'(inReady), 64'd0);
    for (int i = 0; i < hold; i++) begin
      inValid = 1'b1;
      opA = $urandom; opB = $urandom;
      @(posedge clk); #1;
      chk("hold_stable", 64'(outs()), 64'(cap));
      chk("hold_in_ready", 64'(inReady), 64'd0);
      chk("hold_out_valid", 64'(outValid), 64'd1);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    chk("in_ready_after", 64'(inReady), 64'd1);
    chk("out_valid_after", 64'(outValid), 64'd0);
  endtask

  initial begin
    logic [61:0] exp_res;
    int          exp_lat;
    logic [31:0] ra, rb;
    int          ea, eb, mode;

    tbl[0] = '{a:32'h3F800000, b:32'h3F800000, ml:24'h800000, ms:24'h800000, e:8'h7F,
               sl:0, ss:0, g:0, r:0, s:0, sp:0, lat:1, hold:0};
    tbl[1] = '{a:32'h3F800000, b:32'h3E800001, ml:24'h800000, ms:24'h200000, e:8'h7F,
               sl:0, ss:0, g:0, r:1, s:0, sp:0, lat:2, hold:1};
    tbl[2] = '{a:32'h3E800000, b:32'hC0000000, ml:24'h800000, ms:24'h100000, e:8'h80,
               sl:1, ss:0, g:0, r:0, s:0, sp:0, lat:2, hold:0};
    tbl[3] = '{a:32'h4B000000, b:32'h33800001, ml:24'h800000, ms:24'h000000, e:8'h96,
               sl:0, ss:0, g:0, r:0, s:1, sp:0, lat:FAR_LAT, hold:0};
    tbl[4] = '{a:32'h7F800000, b:32'h3F800000, ml:24'h800000, ms:24'h800000, e:8'hFF,
               sl:0, ss:0, g:0, r:0, s:0, sp:1, lat:1, hold:5};
    tbl[5] = '{a:32'h00000001, b:32'h00800000, ml:24'h800000, ms:24'h000001, e:8'h01,
               sl:0, ss:0, g:0, r:0, s:0, sp:0, lat:1, hold:0};
    tbl[6] = '{a:32'h3F800000, b:32'hBF800000, ml:24'h800000, ms:24'h800000, e:8'h7F,
               sl:0, ss:1, g:0, r:0, s:0, sp:0, lat:1, hold:0};
    tbl[7] = '{a:32'h3F800000, b:32'h33400000, ml:24'h800000, ms:24'h000000, e:8'h7F,
               sl:0, ss:0, g:0, r:1, s:1, sp:0, lat:8, hold:0};

    rstN = 1'b0; inValid = 1'b0; outReady = 1'b0; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(inReady), 64'd1);
    chk("reset_out_valid", 64'(outValid), 64'd0);
    chk("reset_outputs", 64'(outs()), 64'd0);
    rstN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].hold);
      chk($sformatf("vec%0d_mant_large", i), 64'(cap[61:38]), 64'(tbl[i].ml));
      chk($sformatf("vec%0d_mant_small", i), 64'(cap[37:14]), 64'(tbl[i].ms));
      chk($sformatf("vec%0d_exponent", i), 64'(cap[13:6]), 64'(tbl[i].e));
      chk($sformatf("vec%0d_signs", i), 64'(cap[5:4]), 64'({tbl[i].sl, tbl[i].ss}));
      chk($sformatf("vec%0d_grs", i), 64'(cap[3:1]), 64'({tbl[i].g, tbl[i].r, tbl[i].s}));
      chk($sformatf("vec%0d_special", i), 64'(cap[0]), 64'(tbl[i].sp));
      chk($sformatf("vec%0d_latency", i), 64'(cap_lat), 64'(tbl[i].lat));
    end

    // Reset while shifting a diff-20 pair discards it.
    opA = 32'h3F800000; opB = 32'h35800000; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_shift_busy", 64'({inReady, outValid}), 64'd0);
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    chk("mid_reset_in_ready", 64'(inReady), 64'd1);
    chk("mid_reset_out_valid", 64'(outValid), 64'd0);
    chk("mid_reset_outputs", 64'(outs()), 64'd0);
    do_op(32'h3F800000, 32'h3F800000, 0);
    model(32'h3F800000, 32'h3F800000, exp_res, exp_lat);
    chk("post_reset_result", 64'(cap), 64'(exp_res));
    chk("post_reset_latency", 64'(cap_lat), 64'(exp_lat));

    for (int n = 0; n < 300; n++) begin
      ea   = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 254));
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: eb = ea;
        1: begin
          eb = ea - int'($urandom_range(0, 30));
          if (eb < 0) eb = 0;
        end
        2: eb = int'($urandom_range(0, 254));
        default: eb = ($urandom_range(0, 1) == 0) ? 0 : 255;
      endcase
      ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        ra ^= rb; rb ^= ra; ra ^= rb;
      end
      do_op(ra, rb, int'($urandom_range(0, 2)));
      model(ra, rb, exp_res, exp_lat);
      chk($sformatf("rand%0d_result a=%h b=%h", n, ra, rb), 64'(cap), 64'(exp_res));
      chk($sformatf("rand%0d_latency", n), 64'(cap_lat), 64'(exp_lat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
